// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: EX/MEM field positions and default widths.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 97;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control bundle bit positions: WB {RegWrite, MemtoReg}, MEM {Branch, MemRead, MemWrite}
  localparam int unsigned RW_BIT  = 4;
  localparam int unsigned MTR_BIT = 3;
  localparam int unsigned BR_BIT  = 2;
  localparam int unsigned MR_BIT  = 1;
  localparam int unsigned MW_BIT  = 0;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned PC_LSB   = 65;
  localparam int unsigned ALU_LSB  = 33;
  localparam int unsigned WD_LSB   = 1;
  localparam int unsigned ZERO_BIT = 0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] wd;
    logic              zero;
  } exmem_data_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register; clear drops the entry and zeroes its control bits.
module pipe_slot #(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = pipe_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] dest_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] dest_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] dest_q;

  // Data and dest are kept on clear so a bubble still shows the last payload
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      dest_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
      dest_q  <= dest_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
  assign dest_o  = dest_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: head + skid slot with valid/ready, flush, bubble
// zeroing of control, forwarding tap and saturating stall counter.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = pipe_pkg::ADDR_W_DEF,
  parameter int unsigned RW_BIT = pipe_pkg::RW_BIT,
  parameter int unsigned CNT_W  = pipe_pkg::CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_dest,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              head_v, skid_v;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;
  logic [ADDR_W-1:0] head_dest, skid_dest, head_dest_in;
  logic              head_load, head_clr, skid_load, skid_clr;
  logic              accept, pop;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign in_ready = rst & ~skid_v;
  assign accept   = in_valid & in_ready;
  assign pop      = head_v & out_ready;

  // Slot control: flush wins; a freed head refills from skid first, then from input
  always_comb begin
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (!head_v || pop) begin
      if (skid_v) begin
        head_load = 1'b1;
        skid_clr  = 1'b1;
      end else if (accept) begin
        head_load = 1'b1;
      end else if (head_v) begin
        head_clr = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
  end

  assign head_ctrl_in = skid_v ? skid_ctrl : in_ctrl;
  assign head_data_in = skid_v ? skid_data : in_data;
  assign head_dest_in = skid_v ? skid_dest : in_dest;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_head (
    .clk     (clk),
    .rst     (rst),
    .load_i  (head_load),
    .clr_i   (head_clr),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .dest_i  (head_dest_in),
    .valid_o (head_v),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data),
    .dest_o  (head_dest)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .dest_i  (in_dest),
    .valid_o (skid_v),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data),
    .dest_o  (skid_dest)
  );

  // Back-pressure counter saturates; only reset clears it
  always_comb begin
    cnt_d = cnt_q;
    if (head_v && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = head_v;
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;
  assign out_dest  = head_dest;
  assign fwd_valid = head_v & head_ctrl[RW_BIT];
  assign fwd_dest  = head_dest;
  assign occ       = 2'(head_v) + 2'(skid_v);
  assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX->MEM pipeline register.
- Carries a control bundle, a data bundle and a write-back destination between two CPU pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, bubble zeroing of control and a saturating stall counter.
- Instanced at the EX/MEM boundary first; reusable at ID/EX and MEM/WB by changing parameters.

Parameters:
- CTRL_W, 5, control bundle width (WB {RegWrite,MemtoReg} plus MEM {Branch,MemRead,MemWrite}).
- DATA_W, 97, data bundle width ({PC[31:0], ALUResult[31:0], WriteData[31:0], Zero}).
- ADDR_W, 5, destination register address width.
- RW_BIT, 4, index of RegWrite within the control bundle; drives the forwarding tap.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  discard all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- in_dest  input  ADDR_W  upstream write-back register address.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes the head this cycle.
- out_ctrl  output  CTRL_W  head control bundle; zero when out_valid=0.
- out_data  output  DATA_W  head data bundle.
- out_dest  output  ADDR_W  head write-back address.
- fwd_valid  output  1  equals out_valid & out_ctrl[RW_BIT].
- fwd_dest  output  ADDR_W  equals out_dest.
- occ  output  2  number of held entries, 0..2.
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Storage:
  - Main register (head) plus skid register, each holding {ctrl, data, dest, valid}.
  - All state updates on posedge clk.
- Reset (rst=0 at posedge):
  - Both valid bits, all ctrl/data/dest fields, occ and stall_cnt clear to 0.
  - in_ready is forced 0 while rst=0.
- Handshake:
  - in_ready = rst & ~skid_valid. It is combinational from registered state only; there is no in_valid->in_ready path.
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Update cases (no flush):
  - Head empty, accept: entry goes to head. out_valid=1 the next cycle (1-cycle latency).
  - Head full, pop, accept, skid empty: new entry goes to head.
  - Head full, pop, skid full: skid moves to head, skid empties. Accept is impossible here because in_ready=0.
  - Head full, no pop, accept: entry goes to skid. in_ready=0 the next cycle.
  - Head full, pop, no accept: head empties, unless the skid refills it.
- Ordering: strict FIFO, no reordering or loss. Data stays stable while out_valid=1 and out_ready=0.
- Bubble: when out_valid=0, out_ctrl reads all-zero, so MemWrite, MemRead, RegWrite and Branch are inactive. out_data and out_dest hold their last values.
- Flush (flush=1 at posedge):
  - Both valid bits clear and stored ctrl fields zero; occ=0 the next cycle.
  - An entry accepted in the flush cycle is dropped. A pop in the flush cycle still counts as consumed downstream.
  - Flush has priority over every update; rst has priority over flush.
- occ = head_valid + skid_valid.
- stall_cnt:
  - Increments on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- Throughput: 1 entry/cycle sustained when out_ready=1 continuously.

Decomposition:
- Shared package pipe_pkg holds:
  - EX/MEM field-position constants: RW_BIT=4, MTR_BIT=3, BR_BIT=2, MR_BIT=1, MW_BIT=0.
  - Data field offsets: PC [96:65], ALU [64:33], WD [32:1], Zero [0].
  - Default widths.
- One natural sub-module, pipe_slot: a single valid+payload register with load/clear enables, instanced twice (head and skid).

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ctrl=0, occ=0, stall_cnt=0. Release -> in_ready=1.
- Streaming: out_ready=1; send ctrl=5'b10100, data with PC=0x40, ALU=0x10, WD=0xAA, Zero=1, dest=7 -> same values at outputs 1 cycle later, fwd_valid=1, fwd_dest=7. Ten back-to-back entries -> ten consecutive outputs, no gaps.
- Back-pressure: out_ready=0; send A then B -> occ=2, in_ready=0, head holds A, stall_cnt increments each cycle. Raise out_ready -> A then B in order; in_ready returns to 1 after the skid drains.
- Flush: occ=2, assert flush together with in_valid=1 entry C -> next cycle occ=0, out_valid=0, out_ctrl=0, C never appears, stall_cnt unchanged.
- Bubble: ctrl with MemWrite=1 consumed, then in_valid=0 -> out_ctrl=0 and fwd_valid=0 while out_data holds its last value.
- Saturation: CNT_W=4, out_ready=0 with the head full for 20 cycles -> stall_cnt stops at 15.
